div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, giving the operand and result width in bits; only 32 is required.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: division request, sampled on rising edges only while busy=0.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 selects DIV (two's complement), 0 selects DIVU; sampled together with start.
REQ-006 The block SHALL have port inA, input, WIDTH bits: the dividend, sampled together with start.
REQ-007 The block SHALL have port inB, input, WIDTH bits: the divisor, sampled together with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: LO value.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: HI value.
REQ-012 The block SHALL have port div_zero, output, 1 bit: high when the last completed operation had inB=0.

Function
REQ-013 The block SHALL implement states IDLE, CALC and FIX.
REQ-014 In IDLE, start=1 SHALL latch is_signed, the operand signs and the magnitudes of inA/inB, clear the partial remainder and iteration counter, set busy=1, and go to CALC; magnitudes equal the raw operands when is_signed=0.
REQ-015 In CALC, each cycle SHALL perform one restoring step: shift {partial remainder, dividend} left by 1, trial-subtract the divisor magnitude in WIDTH+1 bits, keep the difference and shift in quotient bit 1 if it is non-negative, otherwise restore and shift in 0.
REQ-016 After exactly 32 CALC cycles (counter 0..31), the block SHALL go to FIX.
REQ-017 In FIX, the block SHALL register quotient (negated if the operand signs differ and is_signed=1), remainder (negated if the dividend was negative and is_signed=1) and div_zero, pulse done=1, clear busy and return to IDLE.
REQ-018 Latency SHALL be 33 cycles: if start is sampled at edge N, done=1 and results are valid in the cycle following edge N+33.
REQ-019 Signed results SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 Divide by zero (inB=0) SHALL give quotient=0xFFFFFFFF, remainder=inA unchanged, div_zero=1, at the same latency, for both signed and unsigned operation.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0, div_zero=0.
REQ-022 start while busy=1 SHALL be ignored; no queuing and no corruption of the operation in progress.
REQ-023 start may be asserted in the same cycle as done (busy=0); it SHALL be accepted, and done SHALL then pulse again 33 cycles later.
REQ-024 quotient, remainder and div_zero SHALL hold their values from the last completion until the next FIX; they SHALL NOT change during CALC.
REQ-025 Operand inputs SHALL be don't-care while busy=1.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, and clear the counter and internal registers, regardless of the clock.
REQ-027 Reset during CALC or FIX SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL behave as from power-up.

Verification
REQ-028 The bench SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, div_zero=0, done exactly 33 cycles after the start edge, busy high for 33 cycles.
REQ-029 The bench SHALL cover: signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-030 The bench SHALL cover: divide by zero, signed 0xFFFFFFF9/0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFF9, div_zero=1; unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5.
REQ-031 The bench SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 The bench SHALL cover: start re-pulsed with 9/3 at cycle 10 of a 100/7 operation -> ignored, result 14/2; then start with 9/3 in the done cycle -> quotient=3, remainder=0 after 33 more cycles.
REQ-033 The bench SHALL cover: reset asserted asynchronously mid-CALC -> all outputs 0 immediately, no done pulse; a subsequent 20/6 -> quotient=3, remainder=2.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider: operands and start from
// the requester, busy/done and registered results back from the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, inA, inB,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, inA, inB,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU. Produces one quotient bit per clock
// and applies the sign correction in a final cycle (33-cycle latency).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  prem;
  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  dvs;
  logic              neg_q;
  logic              neg_r;
  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  quo_r;
  logic [WIDTH-1:0]  rem_r;
  logic              dz_r;

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // Partial remainder stays below the divisor, so the shifted value minus the
  // divisor always fits in WIDTH+1 signed bits; the MSB is the borrow.
  always_comb begin
    shifted = {prem, dvd[WIDTH-1]};
    trial   = $signed(shifted - {1'b0, dvs});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      prem   <= '0;
      dvd    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q  <= bus.is_signed & (bus.inA[WIDTH-1] ^ bus.inB[WIDTH-1]);
            neg_r  <= bus.is_signed & bus.inA[WIDTH-1];
            dvd    <= magnitude(bus.inA, bus.is_signed);
            dvs    <= magnitude(bus.inB, bus.is_signed);
            prem   <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          // A zero divisor leaves the dividend magnitude in prem, so the
          // remainder correction restores inA; only the quotient is forced.
          quo_r  <= (dvs == '0) ? '1 : cond_neg(dvd, neg_q);
          rem_r  <= cond_neg(prem, neg_r);
          dz_r   <= (dvs == '0);
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/DIVU vectors, latency, busy
// window, start-while-busy, back-to-back start and asynchronous reset abort.
module tb_div_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
    end
  endtask

  // Drives start at the current time; caller must be away from a rising edge.
  task automatic run_op(input string tag, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic z, input bit repulse);
    int cyc;
    int nb;
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.inA       = a;
    bus.inB       = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.inA   = 32'hA5A5_5A5A;
    bus.inB   = 32'h0;
    chk({tag, "_busy_k0"}, {31'b0, bus.busy}, 32'd1);
    chk({tag, "_done_k0"}, {31'b0, bus.done}, 32'd0);
    nb  = bus.busy ? 1 : 0;
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      if (repulse && cyc == 9) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.inA       = 32'd9;
        bus.inB       = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == 16)
        chk({tag, "_hold_q"}, bus.quotient, last_q);
      @(posedge clk); #1;
      cyc++;
      if (bus.busy) nb++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd33);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd33);
    chk({tag, "_q"}, bus.quotient, q);
    chk({tag, "_r"}, bus.remainder, r);
    chk({tag, "_dz"}, {31'b0, bus.div_zero}, {31'b0, z});
    last_q = q;
  endtask

  initial begin
    int dcnt;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.inA       = '0;
    bus.inB       = '0;
    #2;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dz", {31'b0, bus.div_zero}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         1'b0, 1'b0);
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'h2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("s_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0);
    run_op("s_m7_0",   1'b1, 32'hFFFF_FFF9, 32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
    run_op("u5_0",     1'b0, 32'd5,         32'h0,        32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0);
    run_op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 1'b0);
    run_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
    run_op("u100_7rp", 1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         1'b0, 1'b1);
    run_op("u9_3b2b",  1'b0, 32'd9,         32'd3,        32'd3,         32'd0,         1'b0, 1'b0);
    run_op("u5_0b",    1'b0, 32'd5,         32'h0,        32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0);

    // Abort a 100/7 mid-CALC with an asynchronous reset between clock edges.
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.inA       = 32'd100;
    bus.inB       = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_q", bus.quotient, 32'd0);
    chk("arst_r", bus.remainder, 32'd0);
    chk("arst_dz", {31'b0, bus.div_zero}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    chk("arst_no_done", 32'(dcnt), 32'd0);
    chk("arst_idle_busy", {31'b0, bus.busy}, 32'd0);
    last_q = '0;
    @(negedge clk);
    run_op("u20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
